// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM BCD timekeeping, RUN/SET_HR/SET_MIN button FSM,
// 1 Hz tick prescaler with blink phase, and multiplexed 4-digit anode scan.
// Optional macro TWELVE_HOUR_EN selects 12-hour time with a pm output.
module clock_time_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [3:0]  anodes,
  output logic [3:0]  digit_bcd,
  output logic [15:0] time_bcd,
  output logic [1:0]  mode,
`ifdef TWELVE_HOUR_EN
  output logic        pm,
`endif
  output logic        sec_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

`ifdef TWELVE_HOUR_EN
  localparam logic [3:0] HR_T_RST = 4'd1;
  localparam logic [3:0] HR_O_RST = 4'd2;
`else
  localparam logic [3:0] HR_T_RST = 4'd0;
  localparam logic [3:0] HR_O_RST = 4'd0;
`endif

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  mode_t state, state_next;

  logic [PW-1:0] presc;
  logic          presc_wrap, presc_half, blink;
  logic [5:0]    sec;
  logic [3:0]    hr_t, hr_o, min_t, min_o;
  logic [3:0]    hr_t_inc, hr_o_inc, min_t_inc, min_o_inc;
  logic          min_wrap;
  logic          mode_prev, inc_prev, mode_edge, inc_edge;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [3:0]    anodes_next, digit_next;
`ifdef TWELVE_HOUR_EN
  logic          pm_flip;
`endif

  assign presc_wrap = (presc == PRESC_LAST);
  assign presc_half = (presc == PRESC_HALF);
  assign mode_edge  = btn_mode & ~mode_prev;
  assign inc_edge   = btn_inc & ~inc_prev;
  assign time_bcd   = {hr_t, hr_o, min_t, min_o};
  assign mode       = state;

  // Button history for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
    end
  end

  // Mode state register
  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  // Mode sequencing on each btn_mode edge
  always_comb begin
    state_next = state;
    if (mode_edge) begin
      case (state)
        RUN:     state_next = SET_HR;
        SET_HR:  state_next = SET_MIN;
        default: state_next = RUN;
      endcase
    end
  end

  // BCD successor values for the hour and minute fields
  always_comb begin
    hr_t_inc  = hr_t;
    hr_o_inc  = hr_o + 4'd1;
    min_t_inc = min_t;
    min_o_inc = min_o + 4'd1;
    min_wrap  = (min_t == 4'd5) && (min_o == 4'd9);
`ifdef TWELVE_HOUR_EN
    pm_flip = 1'b0;
    if (hr_t == 4'd1 && hr_o == 4'd2) begin
      hr_t_inc = 4'd0;
      hr_o_inc = 4'd1;
    end else if (hr_t == 4'd1 && hr_o == 4'd1) begin
      hr_o_inc = 4'd2;
      pm_flip  = 1'b1;
    end else if (hr_o == 4'd9) begin
      hr_t_inc = 4'd1;
      hr_o_inc = 4'd0;
    end
`else
    if (hr_t == 4'd2 && hr_o == 4'd3) begin
      hr_t_inc = 4'd0;
      hr_o_inc = 4'd0;
    end else if (hr_o == 4'd9) begin
      hr_t_inc = hr_t + 4'd1;
      hr_o_inc = 4'd0;
    end
`endif
    if (min_o == 4'd9) begin
      min_o_inc = 4'd0;
      min_t_inc = (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
    end
  end

  // Prescaler, registered second tick and blink phase
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc    <= '0;
      sec_tick <= 1'b0;
      blink    <= 1'b0;
    end else begin
      sec_tick <= presc_wrap;
      if (mode_edge && state == RUN) presc <= '0;
      else if (presc_wrap)           presc <= '0;
      else                           presc <= presc + PW'(1);
      if (mode_edge)                      blink <= 1'b0;
      else if (presc_half || presc_wrap)  blink <= ~blink;
    end
  end

  // Time registers: RUN carry chain or manual field increments
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec   <= 6'd0;
      min_t <= 4'd0;
      min_o <= 4'd0;
      hr_t  <= HR_T_RST;
      hr_o  <= HR_O_RST;
`ifdef TWELVE_HOUR_EN
      pm    <= 1'b0;
`endif
    end else if (mode_edge) begin
      if (state == RUN) sec <= 6'd0;
    end else begin
      case (state)
        RUN: begin
          if (presc_wrap) begin
            if (sec == 6'd59) begin
              sec   <= 6'd0;
              min_t <= min_t_inc;
              min_o <= min_o_inc;
              if (min_wrap) begin
                hr_t <= hr_t_inc;
                hr_o <= hr_o_inc;
`ifdef TWELVE_HOUR_EN
                if (pm_flip) pm <= ~pm;
`endif
              end
            end else begin
              sec <= sec + 6'd1;
            end
          end
        end
        SET_HR: begin
          if (inc_edge) begin
            hr_t <= hr_t_inc;
            hr_o <= hr_o_inc;
`ifdef TWELVE_HOUR_EN
            if (pm_flip) pm <= ~pm;
`endif
          end
        end
        SET_MIN: begin
          if (inc_edge) begin
            min_t <= min_t_inc;
            min_o <= min_o_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Anode pattern with blink blanking of the field being edited, plus digit mux
  always_comb begin
    anodes_next = ~(4'b0001 << scan_idx);
    if (blink && state == SET_HR)  anodes_next = anodes_next | 4'b1100;
    if (blink && state == SET_MIN) anodes_next = anodes_next | 4'b0011;
    case (scan_idx)
      2'd0:    digit_next = min_o;
      2'd1:    digit_next = min_t;
      2'd2:    digit_next = hr_o;
      default: digit_next = hr_t;
    endcase
  end

  // Scan slot counter and registered display outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt  <= '0;
      scan_idx  <= 2'd0;
      anodes    <= 4'b1110;
      digit_bcd <= 4'd0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      anodes    <= anodes_next;
      digit_bcd <= digit_next;
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed scoreboard bench for clock_time_ctrl
// (TICK_DIV=10, SCAN_DIV=4, 24-hour build).
module tb_clock_time_ctrl;

  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [3:0]  anodes;
  logic [3:0]  digit_bcd;
  logic [15:0] time_bcd;
  logic [1:0]  mode;
  logic        sec_tick;
`ifdef TWELVE_HOUR_EN
  logic        pm;
`endif

  clock_time_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .anodes    (anodes),
    .digit_bcd (digit_bcd),
    .time_bcd  (time_bcd),
    .mode      (mode),
`ifdef TWELVE_HOUR_EN
    .pm        (pm),
`endif
    .sec_tick  (sec_tick)
  );

  always #5 clk = ~clk;

  localparam int SEL_AN   = 0;
  localparam int SEL_DIG  = 1;
  localparam int SEL_TIME = 2;
  localparam int SEL_MODE = 3;
  localparam int SEL_TICK = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          tick_count = 0;
  int          blank_count = 0;
  bit          scan_chk = 1'b0;
  bit          scan_seen = 1'b0;
  logic [3:0]  last_an = 4'b1110;
  logic        prev_tick = 1'b0;

  // Select the DUT output a scoreboard entry refers to
  function automatic logic [15:0] pick(input int sel);
    case (sel)
      SEL_AN:   return {12'd0, anodes};
      SEL_DIG:  return {12'd0, digit_bcd};
      SEL_TIME: return time_bcd;
      SEL_MODE: return {14'd0, mode};
      default:  return {15'd0, sec_tick};
    endcase
  endfunction

  // Single comparison point: counts and reports
  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue an expected output for the monitor
  task automatic checkOutput(input string name, input int sel, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // One clean button press (edge, then release)
  task automatic applyStimulus(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk); #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic holdInc(input int n);
    btn_inc = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    btn_inc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic waitTicks(input int target, input string name);
    int budget;
    budget = 0;
    while (tick_count < target && budget < TICK_DIV * target * 2 + 100) begin
      @(negedge clk);
      budget++;
    end
    if (tick_count < target) compare({"timeout_", name}, 16'(tick_count), 16'(target));
    @(posedge clk); #1;
  endtask

  task automatic waitAnode(input logic [3:0] a, input logic [3:0] dig, input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      @(posedge clk); #1;
      if (anodes === a) found = 1'b1;
    end
    if (found) checkOutput(name, SEL_DIG, {12'd0, dig});
    else       compare({"timeout_", name}, {12'd0, anodes}, {12'd0, a});
  endtask

  // Scoreboard monitor: drains queued expectations away from the active edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      compare(cur.name, pick(cur.sel), cur.exp);
    end
  end

  // Tick counting, pulse width and blank observation
  always @(negedge clk) begin
    if (sec_tick === 1'b1) begin
      tick_count++;
      compare("tick_width", {15'd0, prev_tick}, 16'd0);
    end
    prev_tick = sec_tick;
    if (anodes === 4'b1111) blank_count++;
  end

  // Scan order: each anode change must be the next digit in rotation
  always @(negedge clk) begin
    if (scan_chk && scan_seen && anodes !== last_an)
      compare("scan_order", {12'd0, anodes}, {12'd0, last_an[2:0], last_an[3]});
    last_an   = anodes;
    scan_seen = scan_chk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rst_anodes", SEL_AN, 16'h000E);
    checkOutput("rst_digit", SEL_DIG, 16'h0000);
    checkOutput("rst_time", SEL_TIME, 16'h0000);
    checkOutput("rst_mode", SEL_MODE, 16'h0000);
    checkOutput("rst_tick", SEL_TICK, 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("scan_hold", SEL_AN, 16'h000E);
    repeat (SCAN_DIV) begin @(posedge clk); #1; end
    checkOutput("scan_first_step", SEL_AN, 16'h000D);

    // RUN carry: 600 ticks -> 00:10
    tick_count  = 0;
    blank_count = 0;
    scan_chk    = 1'b1;
    waitTicks(600, "run600");
    checkOutput("run_time", SEL_TIME, 16'h0010);
    checkOutput("run_mode", SEL_MODE, 16'h0000);
    scan_chk = 1'b0;
    compare("run_no_blank", 16'(blank_count), 16'd0);

    // Hour set wrap from 00:00
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("sethr_mode", SEL_MODE, 16'h0001);
    blank_count = 0;
    repeat (40) begin @(posedge clk); #1; end
    compare("sethr_blank_seen", {15'd0, blank_count > 0}, 16'd1);
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (i == 9)  checkOutput("hr_9",  SEL_TIME, 16'h0900);
      if (i == 10) checkOutput("hr_10", SEL_TIME, 16'h1000);
      if (i == 23) checkOutput("hr_23", SEL_TIME, 16'h2300);
      if (i == 24) checkOutput("hr_wrap", SEL_TIME, 16'h0000);
    end
    holdInc(5);
    checkOutput("hr_held_once", SEL_TIME, 16'h0100);

    // Minute set wrap, no carry into hours
    applyStimulus(1'b1, 1'b0);
    checkOutput("setmin_mode", SEL_MODE, 16'h0002);
    blank_count = 0;
    repeat (40) begin @(posedge clk); #1; end
    compare("setmin_blank_seen", {15'd0, blank_count > 0}, 16'd1);
    for (int i = 1; i <= 61; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (i == 59) checkOutput("min_59", SEL_TIME, 16'h0159);
      if (i == 60) checkOutput("min_wrap", SEL_TIME, 16'h0100);
      if (i == 61) checkOutput("min_61", SEL_TIME, 16'h0101);
    end

    // Day wrap: set 23:59 and run 60 ticks
    applyStimulus(1'b1, 1'b0);
    checkOutput("back_run", SEL_MODE, 16'h0000);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("set_23", SEL_TIME, 16'h2301);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("set_2359", SEL_TIME, 16'h2359);
    applyStimulus(1'b1, 1'b0);
    tick_count = 0;
    checkOutput("run_again", SEL_MODE, 16'h0000);
    waitAnode(4'b0111, 4'd2, "dig_hr_tens");
    waitAnode(4'b1011, 4'd3, "dig_hr_ones");
    waitAnode(4'b1101, 4'd5, "dig_min_tens");
    waitAnode(4'b1110, 4'd9, "dig_min_ones");
    waitTicks(59, "tick59");
    checkOutput("day_pre", SEL_TIME, 16'h2359);
    waitTicks(60, "tick60");
    checkOutput("day_wrap", SEL_TIME, 16'h0000);

    // Simultaneous mode+inc in SET_HR, then reset mid-SET
    applyStimulus(1'b1, 1'b0);
    checkOutput("sim_sethr", SEL_MODE, 16'h0001);
    applyStimulus(1'b1, 1'b1);
    checkOutput("sim_mode", SEL_MODE, 16'h0002);
    checkOutput("sim_hours", SEL_TIME, 16'h0000);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sim_min_inc", SEL_TIME, 16'h0001);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midset_mode", SEL_MODE, 16'h0000);
    checkOutput("midset_time", SEL_TIME, 16'h0000);
    checkOutput("midset_anodes", SEL_AN, 16'h000E);
    reset = 1'b1;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
